// File: rtl/output_spike_counter.sv
// ---------------------------------------------------------------------------
// output_spike_counter
// Counts output-layer spikes per neuron over a classification run of sim_time
// network timesteps. It then scans all counters to find the winning neuron,
// which is the highest count with ties going to the lowest index.
//
// Ports
//   clk          : single clock, all logic on posedge
//   rst          : asynchronous active-high reset
//   start        : begin a run (accepted only in IDLE with sim_time != 0)
//   sim_time     : number of timesteps to count, sampled at start
//   spike_valid  : one network timestep finished, spikes is valid
//   spikes       : output-layer spike vector for that timestep
//   rd_en        : counter read request
//   rd_addr      : neuron index to read
//   rd_data      : zero-extended counter value (0 for out-of-range index)
//   rd_valid     : rd_data valid, one cycle after rd_en
//   busy         : high while counting (RUN) or scanning (SCAN)
//   done         : one-cycle pulse when the scan completes
//   winner       : index of the winning neuron from the last completed run
// ---------------------------------------------------------------------------
module output_spike_counter #(
  parameter int NUM_OUTPUTS            = 100,
  parameter int COUNT_WIDTH            = 8,
  parameter int MAX_TIMESTEPS_BITS     = 7,
  parameter int OUTPUT_SPIKE_ADDR_BITS = 7,
  parameter int C_S_AXI_DATA_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [MAX_TIMESTEPS_BITS-1:0]     sim_time,
  input  logic                              spike_valid,
  input  logic [NUM_OUTPUTS-1:0]            spikes,
  input  logic                              rd_en,
  input  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                              rd_valid,
  output logic                              busy,
  output logic                              done,
  output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] winner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0]            CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0]            CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [MAX_TIMESTEPS_BITS-1:0]     TS_ONE   = MAX_TIMESTEPS_BITS'(1);
  localparam logic [OUTPUT_SPIKE_ADDR_BITS-1:0] IDX_ONE  = OUTPUT_SPIKE_ADDR_BITS'(1);
  localparam logic [OUTPUT_SPIKE_ADDR_BITS-1:0] LAST_IDX = OUTPUT_SPIKE_ADDR_BITS'(NUM_OUTPUTS - 1);

  state_t                              state_r;
  state_t                              state_next_s;
  logic [MAX_TIMESTEPS_BITS-1:0]       sim_time_r;
  logic [MAX_TIMESTEPS_BITS-1:0]       ts_r;
  logic [MAX_TIMESTEPS_BITS-1:0]       ts_inc_s;
  logic [COUNT_WIDTH-1:0]              count_r [NUM_OUTPUTS];
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0]   scan_idx_r;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0]   best_idx_r;
  logic [COUNT_WIDTH-1:0]              best_cnt_r;
  logic [COUNT_WIDTH-1:0]              scan_cnt_s;
  logic [COUNT_WIDTH-1:0]              rd_cnt_s;
  logic                                start_ok_s;
  logic                                step_s;
  logic                                last_step_s;
  logic                                scan_gt_s;
  logic                                scan_last_s;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0]   winner_r;
  logic                                busy_r;
  logic                                done_r;
  logic                                rd_valid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]       rd_data_r;

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign winner   = winner_r;

  // Decode run control events and the scan comparison for this cycle.
  always_comb begin
    start_ok_s  = (state_r == IDLE) && start && (sim_time != '0);
    step_s      = (state_r == RUN) && spike_valid;
    ts_inc_s    = ts_r + TS_ONE;
    last_step_s = step_s && (ts_inc_s == sim_time_r);
    scan_cnt_s  = count_r[scan_idx_r];
    // Strictly-greater keeps the earliest index on ties.
    scan_gt_s   = scan_cnt_s > best_cnt_r;
    scan_last_s = (state_r == SCAN) && (scan_idx_r == LAST_IDX);
  end

  // Read mux; indices beyond the counter array read as zero.
  always_comb begin
    rd_cnt_s = '0;
    if (int'(rd_addr) < NUM_OUTPUTS) begin
      rd_cnt_s = count_r[rd_addr];
    end else begin
      rd_cnt_s = '0;
    end
  end

  // Next-state logic for the IDLE/RUN/SCAN controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_next_s = RUN;
        else            state_next_s = IDLE;
      end
      RUN: begin
        if (last_step_s) state_next_s = SCAN;
        else             state_next_s = RUN;
      end
      SCAN: begin
        if (scan_last_s) state_next_s = IDLE;
        else             state_next_s = SCAN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Counters, timestep counter, scan pipeline and run status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) count_r[i] <= '0;
      sim_time_r <= '0;
      ts_r       <= '0;
      scan_idx_r <= '0;
      best_idx_r <= '0;
      best_cnt_r <= '0;
      winner_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= scan_last_s;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) count_r[i] <= '0;
            sim_time_r <= sim_time;
            ts_r       <= '0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          if (step_s) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (spikes[i] && (count_r[i] != CNT_MAX)) count_r[i] <= count_r[i] + CNT_ONE;
            end
            ts_r <= ts_inc_s;
          end
          if (last_step_s) begin
            scan_idx_r <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
          end
        end
        SCAN: begin
          if (scan_gt_s) begin
            best_cnt_r <= scan_cnt_s;
            best_idx_r <= scan_idx_r;
          end
          scan_idx_r <= scan_idx_r + IDX_ONE;
          // Final compare result goes straight into winner as done rises.
          if (scan_last_s) begin
            winner_r <= scan_gt_s ? scan_idx_r : best_idx_r;
            busy_r   <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: one-cycle latency, data zero when not reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_en;
      rd_data_r  <= rd_en ? C_S_AXI_DATA_WIDTH'(rd_cnt_s) : '0;
    end
  end

endmodule
